// File: rtl/line_responder.sv
// Line-oriented command responder: reads one typed line, answers "echo " / "rev "
// commands (or "unknown command"), then raises solved until acknowledged.
module line_responder #(
    parameter int BUF_LEN = 128  // 6..255 so stored lengths and pointers fit 8 bits
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        term_ready,
    input  logic [12:0] term_len,
    input  logic [7:0]  term_char,
    output logic        term_next,
    output logic [7:0]  out_char,
    output logic        out_ready,
    input  logic        char_next,
    output logic        solved,
    input  logic        solved_ack,
    output logic        busy
);

    localparam int AW = $clog2(BUF_LEN);
    localparam logic [8*15-1:0] ERR_MSG = "unknown command";

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_PARSE, S_WRITE, S_TERM, S_SOLVE
    } state_t;

    typedef enum logic [1:0] {
        MODE_ECHO, MODE_REV, MODE_ERR
    } mode_t;

    function automatic logic [7:0] err_char(input logic [3:0] idx);
        err_char = 8'h00;
        for (int i = 0; i < 15; i++)
            if (idx == 4'(i)) err_char = ERR_MSG[8*(14-i) +: 8];
    endfunction

    logic [7:0]  line_buf_q [BUF_LEN];
    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [12:0] rd_cnt_q, rd_cnt_d;
    logic        guard_q, guard_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  last_q, last_d;
    logic        term_next_q, term_next_d;
    logic [7:0]  out_char_q, out_char_d;
    logic        out_ready_q, out_ready_d;
    logic        solved_q, solved_d;
    logic        busy_q;
    logic        buf_we;

    logic [7:0]    stored_len;
    logic [AW-1:0] rev_first;
    logic          is_echo, is_rev;
    logic [7:0]    step_ptr;
    logic [7:0]    step_char;

    // Characters past BUF_LEN are consumed but dropped, so the usable length saturates.
    assign stored_len = (rd_cnt_q >= 13'(BUF_LEN)) ? 8'(BUF_LEN) : rd_cnt_q[7:0];
    assign rev_first  = AW'(stored_len - 8'd1);
    assign is_echo    = (stored_len >= 8'd5) && line_buf_q[0] == "e" && line_buf_q[1] == "c"
                        && line_buf_q[2] == "h" && line_buf_q[3] == "o" && line_buf_q[4] == " ";
    assign is_rev     = (stored_len >= 8'd4) && line_buf_q[0] == "r" && line_buf_q[1] == "e"
                        && line_buf_q[2] == "v" && line_buf_q[3] == " ";
    assign step_ptr   = (mode_q == MODE_REV) ? ptr_q - 8'd1 : ptr_q + 8'd1;
    assign step_char  = (mode_q == MODE_ERR) ? err_char(step_ptr[3:0])
                                             : line_buf_q[step_ptr[AW-1:0]];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        rd_cnt_d    = rd_cnt_q;
        guard_d     = guard_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        term_next_d = 1'b0;
        out_char_d  = out_char_q;
        out_ready_d = out_ready_q;
        solved_d    = solved_q;
        buf_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (term_ready) begin
                    state_d  = S_READ;
                    rd_cnt_d = '0;
                    guard_d  = 1'b0;
                end
            end
            S_READ: begin
                guard_d = 1'b0;
                if (!term_ready) begin
                    state_d = S_PARSE;
                end else if (!guard_q && rd_cnt_q < term_len) begin
                    // The guard cycle lets the terminal present the next character.
                    term_next_d = 1'b1;
                    guard_d     = 1'b1;
                    rd_cnt_d    = rd_cnt_q + 13'd1;
                    buf_we      = rd_cnt_q < 13'(BUF_LEN);
                end
            end
            S_PARSE: begin
                if (stored_len == 8'd0) begin
                    state_d  = S_SOLVE;
                    solved_d = 1'b1;
                end else begin
                    out_ready_d = 1'b1;
                    if (is_echo) begin
                        mode_d = MODE_ECHO;
                        ptr_d  = 8'd5;
                        last_d = stored_len - 8'd1;
                        if (stored_len == 8'd5) begin
                            state_d    = S_TERM;
                            out_char_d = 8'h00;
                        end else begin
                            state_d    = S_WRITE;
                            out_char_d = line_buf_q[5];
                        end
                    end else if (is_rev) begin
                        mode_d = MODE_REV;
                        ptr_d  = stored_len - 8'd1;
                        last_d = 8'd4;
                        if (stored_len == 8'd4) begin
                            state_d    = S_TERM;
                            out_char_d = 8'h00;
                        end else begin
                            state_d    = S_WRITE;
                            out_char_d = line_buf_q[rev_first];
                        end
                    end else begin
                        mode_d     = MODE_ERR;
                        ptr_d      = 8'd0;
                        last_d     = 8'd14;
                        state_d    = S_WRITE;
                        out_char_d = err_char(4'd0);
                    end
                end
            end
            S_WRITE: begin
                if (char_next) begin
                    if (ptr_q == last_q) begin
                        state_d    = S_TERM;
                        out_char_d = 8'h00;
                    end else begin
                        ptr_d      = step_ptr;
                        out_char_d = step_char;
                    end
                end
            end
            S_TERM: begin
                if (char_next) begin
                    state_d     = S_SOLVE;
                    out_ready_d = 1'b0;
                    solved_d    = 1'b1;
                end
            end
            S_SOLVE: begin
                if (solved_ack) begin
                    state_d  = S_IDLE;
                    solved_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ERR;
            rd_cnt_q    <= '0;
            guard_q     <= 1'b0;
            ptr_q       <= '0;
            last_q      <= '0;
            term_next_q <= 1'b0;
            out_char_q  <= '0;
            out_ready_q <= 1'b0;
            solved_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rd_cnt_q    <= rd_cnt_d;
            guard_q     <= guard_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            term_next_q <= term_next_d;
            out_char_q  <= out_char_d;
            out_ready_q <= out_ready_d;
            solved_q    <= solved_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    // NOTE: the line buffer has no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) line_buf_q[rd_cnt_q[AW-1:0]] <= term_char;
    end

    assign term_next = term_next_q;
    assign out_char  = out_char_q;
    assign out_ready = out_ready_q;
    assign solved    = solved_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_line_responder.sv
// Bench for line_responder: acts as the terminal, feeding lines and consuming responses.
module tb_line_responder;

    localparam int BUF_LEN = 128;
    localparam int BUDGET  = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        term_ready = 1'b0;
    logic [12:0] term_len = '0;
    logic [7:0]  term_char = '0;
    logic        term_next;
    logic [7:0]  out_char;
    logic        out_ready;
    logic        char_next = 1'b0;
    logic        solved;
    logic        solved_ack = 1'b0;
    logic        busy;

    line_responder #(.BUF_LEN(BUF_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .term_ready(term_ready), .term_len(term_len), .term_char(term_char),
        .term_next(term_next),
        .out_char(out_char), .out_ready(out_ready), .char_next(char_next),
        .solved(solved), .solved_ack(solved_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] cmd;
        int           len;
        logic [127:0] exp;
        int           exp_len;
        bit           no_out;
    } vec_t;

    int checks = 0;
    int errors = 0;

    byte unsigned line_mem [256];
    byte unsigned got_q[$];
    byte unsigned exp_q[$];

    int r_pulses, r_spacing_bad, r_oready, r_after_bad, r_stable_bad;
    int r_solved_cyc, r_solved_drop, r_timeout;
    logic r_solved_after, r_busy_after;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_stream(input string name);
        int d;
        d = -1;
        check({name, " length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i] && d < 0) d = i;
        check({name, " first differing char index"}, d, -1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; term_ready = 1'b0; char_next = 1'b0; solved_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_packed(input logic [127:0] s, input int len);
        for (int i = 0; i < len; i++) line_mem[i] = s[8*(len-1-i) +: 8];
    endtask

    // Reference: the answer to a line is derived from the command rules alone.
    task automatic build_expected(input int len);
        int n;
        bit is_e, is_r;
        string e, r, u;
        e = "echo "; r = "rev "; u = "unknown command";
        n = (len < BUF_LEN) ? len : BUF_LEN;
        exp_q.delete();
        if (n == 0) return;
        is_e = (n >= 5);
        for (int i = 0; i < 5; i++) if (line_mem[i] != e[i]) is_e = 0;
        is_r = (n >= 4);
        for (int i = 0; i < 4; i++) if (line_mem[i] != r[i]) is_r = 0;
        if (is_e)      for (int i = 5; i < n; i++)   exp_q.push_back(line_mem[i]);
        else if (is_r) for (int i = n-1; i >= 4; i--) exp_q.push_back(line_mem[i]);
        else           for (int i = 0; i < 15; i++)  exp_q.push_back(u[i]);
        exp_q.push_back(8'h00);
    endtask

    // Terminal behaviour for one command; all sampling and driving happens on negedges.
    task automatic run_cmd(input int len, input int ack_delay, input int stall_at,
                           input int stall_len, input bit rand_hold, input int abort_at);
        int ci, last_pulse, solved_cnt, stall_left;
        bit out_done, ack_sent, done, stalled, prev_skip, skip;
        logic [7:0] prev_char;
        got_q.delete();
        r_pulses = 0; r_spacing_bad = 0; r_oready = 0; r_after_bad = 0; r_stable_bad = 0;
        r_solved_cyc = -1; r_solved_drop = 0; r_timeout = 0;
        r_solved_after = 1'b1; r_busy_after = 1'b1;
        ci = 0; last_pulse = -100; solved_cnt = 0; stall_left = 0;
        out_done = 0; ack_sent = 0; done = 0; stalled = 0; prev_skip = 0; prev_char = 0;
        term_len   = 13'(len);
        term_char  = (len > 0) ? line_mem[0] : 8'h00;
        term_ready = 1'b1;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            char_next = 1'b0;
            if (ack_sent) begin
                solved_ack     = 1'b0;
                r_solved_after = solved;
                r_busy_after   = busy;
                done = 1;
            end else begin
                if (term_next) begin
                    r_pulses++;
                    if (cyc - last_pulse < 2) r_spacing_bad++;
                    last_pulse = cyc;
                    ci++;
                    term_char = (ci < len) ? line_mem[ci] : 8'h00;
                end
                if (ci >= len) term_ready = 1'b0;
                if (out_ready) begin
                    r_oready++;
                    if (out_done) r_after_bad++;
                    else begin
                        if (prev_skip && out_char !== prev_char) r_stable_bad++;
                        skip = rand_hold && ($urandom_range(0, 2) == 0);
                        if (!stalled && stall_at >= 0 && got_q.size() == stall_at) begin
                            stalled = 1; stall_left = stall_len;
                        end
                        if (stall_left > 0) begin stall_left--; skip = 1; end
                        if (abort_at >= 0 && got_q.size() == abort_at) begin done = 1; skip = 1; end
                        if (!skip) begin
                            got_q.push_back(out_char);
                            char_next = 1'b1;
                            if (out_char == 8'h00) out_done = 1;
                        end
                        prev_skip = skip;
                        prev_char = out_char;
                    end
                end else prev_skip = 0;
                if (solved) begin
                    if (r_solved_cyc < 0) r_solved_cyc = cyc;
                    solved_cnt++;
                    if (solved_cnt >= ack_delay) begin solved_ack = 1'b1; ack_sent = 1; end
                end else if (solved_cnt > 0) r_solved_drop++;
            end
        end
        if (!done) begin
            r_timeout = 1;
            apply_reset();
        end
    endtask

    task automatic check_run(input string name, input int len);
        check({name, " timeout"}, r_timeout, 0);
        check({name, " term_next count"}, r_pulses, len);
        check({name, " term_next spacing violations"}, r_spacing_bad, 0);
        check_stream(name);
        check({name, " out_ready after terminator"}, r_after_bad, 0);
        check({name, " out_char changed while stalled"}, r_stable_bad, 0);
        check({name, " solved dropped before ack"}, r_solved_drop, 0);
        check({name, " solved after ack"}, r_solved_after, 0);
        check({name, " busy after ack"}, r_busy_after, 0);
        if (exp_q.size() == 0) check({name, " out_ready cycles"}, r_oready, 0);
    endtask

    function automatic vec_t mk(input logic [127:0] cmd, input int len,
                                input logic [127:0] exp, input int exp_len, input bit no_out);
        vec_t v;
        v.cmd = cmd; v.len = len; v.exp = exp; v.exp_len = exp_len; v.no_out = no_out;
        return v;
    endfunction

    initial begin
        vec_t vecs[10];
        string pre;
        int kind, body, len;

        vecs[0] = mk("echo hi",    7, "hi",              2,  0);
        vecs[1] = mk("rev abc",    7, "cba",             3,  0);
        vecs[2] = mk("",           0, "",                0,  1);
        vecs[3] = mk("echo ",      5, "",                0,  0);
        vecs[4] = mk("rev ",       4, "",                0,  0);
        vecs[5] = mk("rev",        3, "unknown command", 15, 0);
        vecs[6] = mk("echo",       4, "unknown command", 15, 0);
        vecs[7] = mk("rev x",      5, "x",               1,  0);
        vecs[8] = mk("Echo hi",    7, "unknown command", 15, 0);
        vecs[9] = mk("echo  a b",  9, " a b",            4,  0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset outputs", {term_next, out_ready, out_char, solved, busy}, 0);

        char_next = 1'b1; solved_ack = 1'b1;
        @(negedge clk);
        char_next = 1'b0; solved_ack = 1'b0;
        @(negedge clk);
        check("idle ignores strobes", {busy, out_ready, solved}, 0);

        for (int i = 0; i < 10; i++) begin
            load_packed(vecs[i].cmd, vecs[i].len);
            exp_q.delete();
            if (!vecs[i].no_out) begin
                for (int k = 0; k < vecs[i].exp_len; k++)
                    exp_q.push_back(vecs[i].exp[8*(vecs[i].exp_len-1-k) +: 8]);
                exp_q.push_back(8'h00);
            end
            run_cmd(vecs[i].len, 2, -1, 0, 0, -1);
            check_run($sformatf("vec%0d", i), vecs[i].len);
        end

        // "echo hi" with a long-held solved
        load_packed("echo hi", 7);
        exp_q = '{8'h68, 8'h69, 8'h00};
        run_cmd(7, 8, -1, 0, 0, -1);
        check_run("echo_hi held", 7);

        // empty line: solved must follow quickly
        exp_q.delete();
        run_cmd(0, 2, -1, 0, 0, -1);
        check_run("empty", 0);
        check("empty solved within 3 cycles", r_solved_cyc < 3, 1);

        // "ls" with a 5000-cycle stall mid-line
        load_packed("ls", 2);
        exp_q = '{"u", "n", "k", "n", "o", "w", "n", " ", "c", "o", "m", "m", "a", "n", "d", 8'h00};
        run_cmd(2, 2, 5, 5000, 0, -1);
        check_run("ls stall", 2);

        // 200-character line overflowing the buffer
        for (int i = 0; i < 200; i++) line_mem[i] = "x";
        load_packed("echo ", 5);
        exp_q.delete();
        for (int i = 0; i < 123; i++) exp_q.push_back("x");
        exp_q.push_back(8'h00);
        run_cmd(200, 2, -1, 0, 0, -1);
        check_run("long200", 200);

        // reset in the middle of WRITE
        load_packed("echo hello", 10);
        run_cmd(10, 2, -1, 0, 0, 2);
        check("mid-write out_ready before reset", out_ready, 1);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", {term_next, out_ready, out_char, solved, busy}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle after reset release", {busy, out_ready, solved}, 0);
        load_packed("echo a", 6);
        exp_q = '{8'h61, 8'h00};
        run_cmd(6, 2, -1, 0, 0, -1);
        check_run("echo_a after reset", 6);

        // randomized lines against the reference
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 4);
            body = $urandom_range(0, 12);
            case (kind)
                0: pre = "echo ";
                1: pre = "rev ";
                2: pre = "";
                3: begin pre = ""; body = 0; end
                default: begin
                    pre  = ($urandom_range(0, 1) == 0) ? "echo " : "rev ";
                    body = $urandom_range(120, 190);
                end
            endcase
            if (kind == 2) body = body + 1;
            len = pre.len() + body;
            for (int i = 0; i < pre.len(); i++) line_mem[i] = pre[i];
            for (int i = pre.len(); i < len; i++)
                line_mem[i] = (kind == 2) ? 8'($urandom_range(97, 122)) : 8'($urandom_range(1, 255));
            build_expected(len);
            run_cmd(len, $urandom_range(1, 4), -1, 0, 1, -1);
            check_run($sformatf("rand%0d", t), len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
